// File: rtl/rot_tap_buf_if.sv
// rot_tap_buf_if: write, rotate-command and tap/phase signals of rot_tap_buf
interface rot_tap_buf_if #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_TAPS  = 6
);
    localparam int AW = $clog2(DEPTH);
    logic                          in_valid;
    logic                          in_ready;
    logic [BIT_WIDTH-1:0]          in_data;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [AW-1:0]                 cmd_shamt;
    logic [NUM_TAPS*BIT_WIDTH-1:0] tap_data;
    logic                          tap_valid;
    logic [AW-1:0]                 phase;
    modport master (
        output in_valid, in_data, cmd_valid, cmd_shamt,
        input  in_ready, cmd_ready, tap_data, tap_valid, phase
    );
    modport slave (
        input  in_valid, in_data, cmd_valid, cmd_shamt,
        output in_ready, cmd_ready, tap_data, tap_valid, phase
    );
endinterface

// File: rtl/rot_tap_buf.sv
// rot_tap_buf: shift-filled slot buffer that rotates on command and exposes fixed taps
module rot_tap_buf #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_TAPS  = 6,
    parameter logic [NUM_TAPS*$clog2(DEPTH)-1:0] TAP_IDX =
        {4'd1, 4'd15, 4'd2, 4'd14, 4'd3, 4'd13}
) (
    input logic         clk,
    input logic         rst_n,
    input logic         clr,
    rot_tap_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {FILL, RUN} state_t;
    state_t               state_q, state_d;
    logic [AW-1:0]        fill_q, fill_d;
    logic [AW-1:0]        phase_q, phase_d;
    logic [BIT_WIDTH-1:0] slot_q [DEPTH];
    logic [BIT_WIDTH-1:0] slot_d [DEPTH];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            fill_q  <= '0;
            phase_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
        end
    end
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        phase_d = phase_q;
        slot_d  = slot_q;
        if (clr) begin
            state_d = FILL;
            fill_d  = '0;
            phase_d = '0;
            for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
        end else if (state_q == FILL) begin
            if (bus.in_valid) begin
                for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
                slot_d[DEPTH-1] = bus.in_data;
                // fill count wraps to zero on the DEPTH-th word
                fill_d  = fill_q + AW'(1);
                state_d = (fill_q == AW'(DEPTH - 1)) ? RUN : FILL;
            end
        end else begin
            if (bus.cmd_valid) begin
                for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[AW'(i) + bus.cmd_shamt];
                phase_d = phase_q + bus.cmd_shamt;
            end
            if (bus.in_valid) slot_d[DEPTH-1] = bus.in_data;
        end
    end
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign bus.tap_data[k*BIT_WIDTH +: BIT_WIDTH] = slot_q[TAP_IDX[k*AW +: AW]];
    end
    assign bus.in_ready  = 1'b1;
    assign bus.cmd_ready = (state_q == RUN);
    assign bus.tap_valid = (state_q == RUN);
    assign bus.phase     = phase_q;
endmodule

// File: doc/rot_tap_buf.md
ROT_TAP_BUF -- requirements
Module: rot_tap_buf

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: width of each storage slot.
REQ-002 SHALL have parameter DEPTH, default 16: number of slots; power of two, at least 4; AW = log2(DEPTH).
REQ-003 SHALL have parameter NUM_TAPS, default 6: number of read taps.
REQ-004 SHALL have parameter TAP_IDX, width NUM_TAPS*AW, default {1,15,2,14,3,13}: slot index per tap, tap0 in LSBs (tap0=13, tap1=3, tap2=14, tap3=2, tap4=15, tap5=1).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 clr  input  1  synchronous clear, active-high.
REQ-008 in_valid  input  1  in_data offered.
REQ-009 in_ready  output  1  in_data accepted when in_valid && in_ready.
REQ-010 in_data  input  BIT_WIDTH  word to write.
REQ-011 cmd_valid  input  1  rotate command offered.
REQ-012 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-013 cmd_shamt  input  AW  rotate amount, 0..DEPTH-1.
REQ-014 tap_data  output  NUM_TAPS*BIT_WIDTH  tap k at bits [k*BIT_WIDTH +: BIT_WIDTH] = slot TAP_IDX[k].
REQ-015 tap_valid  output  1  high in RUN only.
REQ-016 phase  output  AW  cumulative rotation modulo DEPTH.

Function
REQ-017 SHALL implement two states: FILL and RUN; the state is registered.
REQ-018 In FILL: in_ready=1, cmd_ready=0, tap_valid=0; cmd_valid SHALL be ignored.
REQ-019 In FILL, each accepted word SHALL shift slot i <= slot i+1 for i<DEPTH-1, slot DEPTH-1 <= in_data, and increment an internal fill count.
REQ-020 The DEPTH-th accepted word in FILL SHALL move the state to RUN on the same edge; fill count returns to 0; phase stays 0.
REQ-021 In RUN: in_ready=1, cmd_ready=1, tap_valid=1.
REQ-022 Accepted command in RUN SHALL rotate in one cycle: slot i <= slot (i+cmd_shamt) mod DEPTH, all i.
REQ-023 Accepted command SHALL set phase <= (phase + cmd_shamt) mod DEPTH; wraparound is silent.
REQ-024 cmd_shamt=0 SHALL leave slots and phase unchanged.
REQ-025 Accepted word in RUN without a command SHALL overwrite slot DEPTH-1 only; no shift.
REQ-026 Accepted word and command in the same RUN cycle: the rotation applies first, then slot DEPTH-1 <= in_data.
REQ-027 tap_data and phase SHALL be driven directly from registers; updates are visible the cycle after the accepting edge.
REQ-028 clr=1 SHALL on the next edge zero all slots, phase and fill count, and enter FILL.
REQ-029 clr SHALL override any simultaneous word or command; both are dropped.
REQ-030 No other state transitions SHALL exist.

Reset
REQ-031 rst_n=0 at a rising edge SHALL zero all slots, phase and fill count, and enter FILL.
REQ-032 Output values after reset: in_ready=1, cmd_ready=0, tap_valid=0, tap_data=0, phase=0.
REQ-033 Reset SHALL take priority over clr and all handshakes, including partway through FILL.

Verification
REQ-034 Fill: with defaults, write 0..15 on consecutive cycles -> RUN after the 16th; tap_valid=1; taps = 13,3,14,2,15,1; phase=0.
REQ-035 Rotate: from REQ-034, apply cmd_shamt=1 -> taps = 14,4,15,3,0,2; phase=1.
REQ-036 Rotate with load: from REQ-034, apply cmd_shamt=4 and in_data=0xAA together -> slot15=0xAA; tap0=1; tap2=2; phase=4.
REQ-037 Wraparound: phase=12, apply cmd_shamt=5 -> phase=1; slot i holds its prior slot (i+5) mod 16.
REQ-038 Reset mid-fill: drive rst_n low after 7 words -> FILL; all taps 0; 16 new words are needed to reach RUN.
REQ-039 Clear priority: clr with cmd_valid and in_valid in RUN -> FILL; slots=0; phase=0; command and word dropped.
